alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle MIPS ALU: same op encoding and set (ADD/SUB/OR/AND/NOR/LUI/SLL/SRL/pass-through/pass-through-to-PC), plus SLT and an iterative multiply/divide unit writing HI/LO.
- All results are registered behind a start/busy/done handshake, so the datapath issues one op and stalls on busy_o.
- Sits in the EX stage; hazard unit stalls the pipeline while busy_o=1.

Parameters:
- DATA_WIDTH, 32, operand/result width (>=8, even).
- SHAMT_WIDTH, 5, shift-amount width; only the low log2(DATA_WIDTH) bits are used.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  issue op; accepted only when busy_o=0.
- alu_operation_i  in  4  opcode, sampled on accept.
- a_i  in  DATA_WIDTH  operand A (rs), sampled on accept.
- b_i  in  DATA_WIDTH  operand B (rt/imm), sampled on accept.
- shamt_i  in  SHAMT_WIDTH  shift amount, sampled on accept.
- busy_o  out  1  multi-cycle op in progress.
- done_o  out  1  one-cycle pulse; result outputs valid.
- alu_data_o  out  DATA_WIDTH  registered result of single-cycle ops.
- zero_o  out  1  alu_data_o==0, registered with alu_data_o.
- topc_o  out  1  registered; 1 when the last op was NOTANDPC.
- hi_o  out  DATA_WIDTH  HI register (product high / remainder).
- lo_o  out  DATA_WIDTH  LO register (product low / quotient).
- div_by_zero_o  out  1  pulses with done_o for DIV/DIVU with b=0.

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE; an in-flight op is aborted and HI/LO cleared.
- Opcodes:
  - Existing: SUB=0001, OR=0010, ADD=0011, LUI=0100, SLL=0101, SRL=0110, AND=0111, NOR=1000, NOTHING=1010, NOTANDPC=1011.
  - New: SLT=1001, MULT=1100, MULTU=1101, DIV=1110, DIVU=1111.
  - 0000 yields alu_data_o=0.
- Single-cycle ops:
  - Accepted at edge N; at edge N+1 alu_data_o, zero_o and topc_o update and done_o=1 for one cycle.
  - busy_o stays 0; back-to-back issue every cycle is legal.
  - HI/LO are untouched.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH. SLT is a signed compare, result 1 or 0. SLL/SRL are logical shifts of b. LUI = {b[DATA_WIDTH/2-1:0], zeros}.
- Multi-cycle ops: alu_data_o, zero_o and topc_o hold their previous values.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + accept of MULT/MULTU -> MUL; accept of DIV/DIVU with b!=0 -> DIV.
  - IDLE + accept of DIV/DIVU with b==0 -> FIN directly.
  - MUL/DIV run exactly DATA_WIDTH iterations, then -> FIN. FIN -> IDLE.
- Multiply/divide timing:
  - Accept at edge N; busy_o=1 from N+1 through the last iteration; iterations on edges N+1..N+W.
  - At edge N+W+1: HI/LO written, done_o=1, busy_o=0.
  - Total latency is W+1 cycles.
- Multiply: shift-add on magnitudes; signed ops negate the 2W product when sign(a)^sign(b).
- Divide: restoring, magnitudes.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - MIN/-1 gives lo=MIN, hi=0.
- Divide by zero: FIN at N+1. hi=a, lo=all ones, div_by_zero_o=1 with done_o.
- start_i while busy_o=1 is ignored (no queueing); the operand inputs may change freely during busy.

Optional Feature:
- ALU_OVF_EN:
  - Defined: adds output overflow_o (1 bit), registered with alu_data_o. It is 1 when ADD/SUB overflows in signed arithmetic, else 0; reset 0.
  - Undefined: the port is absent and no overflow logic exists.
  - Results are identical in both builds.

Decomposition:
- Package alu_pkg: 4-bit opcode localparams/enum, FSM state typedef, DATA_WIDTH default.
- Sub-module alu_mdu_iter: the MUL/DIV iteration datapath with a counter, accumulator and sign fixup; top-level holds the FSM, handshake and single-cycle ops.

Test Plan:
- ADD a=7 b=5 start at N -> cycle N+1: alu_data_o=12, zero_o=0, done_o=1, busy_o=0; SUB 5-5 next cycle -> 0, zero_o=1.
- MULT a=-3 b=4 (W=32) -> busy_o for 32 cycles, done_o at N+33: hi=FFFFFFFF, lo=FFFFFFF4; MULTU FFFFFFFF*2 -> hi=1, lo=FFFFFFFE.
- DIV a=-7 b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
- DIVU a=9 b=0 -> done_o at N+1, div_by_zero_o=1, hi=9, lo=FFFFFFFF.
- start_i=1 with ADD issued mid-MULT -> ignored, MULT result unchanged, alu_data_o unchanged; reset asserted mid-DIV -> busy_o=0 and hi/lo=0 immediately.
- ALU_OVF_EN build: ADD 7FFFFFFF+1 -> alu_data_o=80000000, overflow_o=1; SLT -1,1 -> 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and default width for the ALU/MDU.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_ZERO     = 4'b0000,
        OP_SUB      = 4'b0001,
        OP_OR       = 4'b0010,
        OP_ADD      = 4'b0011,
        OP_LUI      = 4'b0100,
        OP_SLL      = 4'b0101,
        OP_SRL      = 4'b0110,
        OP_AND      = 4'b0111,
        OP_NOR      = 4'b1000,
        OP_SLT      = 4'b1001,
        OP_NOTHING  = 4'b1010,
        OP_NOTANDPC = 4'b1011,
        OP_MULT     = 4'b1100,
        OP_MULTU    = 4'b1101,
        OP_DIV      = 4'b1110,
        OP_DIVU     = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } alu_state_e;

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Issue/result bundle between the EX-stage datapath and alu_mdu.
// overflow_o exists only when ALU_OVF_EN is defined.
interface alu_mdu_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   start_i;
    logic [3:0]             alu_operation_i;
    logic [DATA_WIDTH-1:0]  a_i;
    logic [DATA_WIDTH-1:0]  b_i;
    logic [SHAMT_WIDTH-1:0] shamt_i;
    logic                   busy_o;
    logic                   done_o;
    logic [DATA_WIDTH-1:0]  alu_data_o;
    logic                   zero_o;
    logic                   topc_o;
    logic [DATA_WIDTH-1:0]  hi_o;
    logic [DATA_WIDTH-1:0]  lo_o;
    logic                   div_by_zero_o;
`ifdef ALU_OVF_EN
    logic                   overflow_o;
`endif

    modport master (
        output start_i, alu_operation_i, a_i, b_i, shamt_i,
        input  busy_o, done_o, alu_data_o, zero_o, topc_o, hi_o, lo_o, div_by_zero_o
`ifdef ALU_OVF_EN
        , input overflow_o
`endif
    );

    modport slave (
        input  start_i, alu_operation_i, a_i, b_i, shamt_i,
        output busy_o, done_o, alu_data_o, zero_o, topc_o, hi_o, lo_o, div_by_zero_o
`ifdef ALU_OVF_EN
        , output overflow_o
`endif
    );

endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative multiply (shift-add) / divide (restoring) datapath on operand magnitudes,
// with a down-counter and sign fixup of the result that the final step produces.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [W-1:0]   acc_q, low_q, opnd_q;
    logic [CW-1:0]  cnt_q;
    logic           div_q, neg_q, neg_rem_q;

    logic           sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_add;
    logic [2*W-1:0] mul_sh;
    logic [W:0]     div_sh, div_trial;
    logic [W-1:0]   acc_n, low_n;
    logic [2*W-1:0] prod, prod_s;

    assign sign_a = is_signed & a[W-1];
    assign sign_b = is_signed & b[W-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;
    assign last   = (cnt_q == CW'(1));

    // acc holds the product high half / partial remainder, low the multiplier / quotient
    always_comb begin
        mul_add   = low_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
        mul_sh    = {mul_add, low_q[W-1:1]};
        div_sh    = {acc_q, low_q[W-1]};
        div_trial = div_sh - {1'b0, opnd_q};
        acc_n     = mul_sh[2*W-1:W];
        low_n     = mul_sh[W-1:0];
        if (div_q) begin
            if (!div_trial[W]) begin
                acc_n = div_trial[W-1:0];
                low_n = {low_q[W-2:0], 1'b1};
            end else begin
                acc_n = div_sh[W-1:0];
                low_n = {low_q[W-2:0], 1'b0};
            end
        end
        prod   = {acc_n, low_n};
        prod_s = neg_q ? -prod : prod;
        if (div_q) begin
            res_hi = neg_rem_q ? -acc_n : acc_n;
            res_lo = neg_q ? -low_n : low_n;
        end else begin
            res_hi = prod_s[2*W-1:W];
            res_lo = prod_s[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load) begin
            acc_q     <= '0;
            low_q     <= mag_a;
            opnd_q    <= mag_b;
            cnt_q     <= CW'(W);
            div_q     <= is_div;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
        end else if (step) begin
            acc_q <= acc_n;
            low_q <= low_n;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// MIPS EX-stage ALU with registered results and an iterative MUL/DIV unit behind
// a start/busy/done handshake. Define ALU_OVF_EN to add the signed-overflow flag.
//
// state   | meaning
// IDLE    | waiting for start_i
// MUL     | shift-add multiply iterations running
// DIV     | restoring divide iterations running
// FIN     | cycle in which a MUL/DIV result is presented with done_o
module alu_mdu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);
    localparam int W    = DATA_WIDTH;
    localparam int HALF = DATA_WIDTH / 2;
    localparam logic [SHAMT_WIDTH-1:0] SH_MASK = SHAMT_WIDTH'(DATA_WIDTH - 1);

    alu_state_e state_q, state_d;

    logic [3:0]             op;
    logic [W-1:0]           a, b;
    logic [SHAMT_WIDTH-1:0] sh;
    logic                   busy, accept, is_mul, is_div, single, div_zero;
    logic                   iter_load, last;
    logic [W-1:0]           res_hi, res_lo;
    logic [W-1:0]           sum, diff, alu_res;

    logic [W-1:0]           alu_data_q, hi_q, lo_q;
    logic                   zero_q, topc_q, done_q, dbz_q;

    assign op       = bus.alu_operation_i;
    assign a        = bus.a_i;
    assign b        = bus.b_i;
    assign sh       = bus.shamt_i & SH_MASK;
    assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign accept   = bus.start_i && !busy;
    assign is_mul   = op_is_mul(op);
    assign is_div   = op_is_div(op);
    assign single   = !is_mul && !is_div;
    assign div_zero = (b == '0);
    assign sum      = a + b;
    assign diff     = a - b;

    always_comb begin
        state_d   = state_q;
        iter_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (accept && is_mul) begin
                    state_d   = ST_MUL;
                    iter_load = 1'b1;
                end else if (accept && is_div) begin
                    if (div_zero) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d   = ST_DIV;
                        iter_load = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: if (last) state_d = ST_FIN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:                  alu_res = sum;
            OP_SUB:                  alu_res = diff;
            OP_OR:                   alu_res = a | b;
            OP_AND:                  alu_res = a & b;
            OP_NOR:                  alu_res = ~(a | b);
            OP_LUI:                  alu_res = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLL:                  alu_res = b << sh;
            OP_SRL:                  alu_res = b >> sh;
            OP_SLT:                  alu_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_NOTHING, OP_NOTANDPC: alu_res = a;
            default:                 alu_res = '0;
        endcase
    end

    alu_mdu_iter #(.DATA_WIDTH(W)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (iter_load),
        .step      (busy),
        .is_div    (is_div),
        .is_signed (op_is_signed(op)),
        .a         (a),
        .b         (b),
        .last      (last),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            alu_data_q <= '0;
            zero_q     <= 1'b0;
            topc_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            if (accept && single) begin
                alu_data_q <= alu_res;
                zero_q     <= (alu_res == '0);
                topc_q     <= (op == OP_NOTANDPC);
                done_q     <= 1'b1;
            end
            // divide by zero skips the iterations: HI keeps the dividend, LO saturates
            if (accept && is_div && div_zero) begin
                hi_q   <= a;
                lo_q   <= '1;
                dbz_q  <= 1'b1;
                done_q <= 1'b1;
            end
            if (busy && last) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
            end
        end
    end

`ifdef ALU_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = 1'b0;
        case (op)
            OP_ADD:  ovf_d = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            OP_SUB:  ovf_d = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept && single) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.overflow_o = ovf_q;
`endif

    assign bus.busy_o        = busy;
    assign bus.done_o        = done_q;
    assign bus.alu_data_o    = alu_data_q;
    assign bus.zero_o        = zero_q;
    assign bus.topc_o        = topc_q;
    assign bus.hi_o          = hi_q;
    assign bus.lo_o          = lo_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed scoreboard bench for alu_mdu (DATA_WIDTH=32): expectations are queued at
// issue and checked when done_o pulses; also checks reset, busy length and aborts.
module tb_alu_mdu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    alu_mdu_if #(.DATA_WIDTH(W), .SHAMT_WIDTH(5)) bus ();

    alu_mdu #(.DATA_WIDTH(W), .SHAMT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] tag;
        int          due;
        logic [31:0] data;
        logic        zero;
        logic        topc;
        logic        ovf;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] m_data = '0, m_hi = '0, m_lo = '0;
    logic        m_zero = 1'b0, m_topc = 1'b0, m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        bus.start_i         = 1'b1;
        bus.alu_operation_i = op;
        bus.a_i             = a;
        bus.b_i             = b;
        bus.shamt_i         = sh;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic push(input logic [63:0] tag, input int due, input logic dbz);
        exp_t e;
        e.tag = tag;   e.due = due;     e.data = m_data; e.zero = m_zero;
        e.topc = m_topc; e.ovf = m_ovf; e.hi = m_hi;     e.lo = m_lo;
        e.dbz = dbz;
        sb.push_back(e);
    endtask

    task automatic sc(input logic [63:0] tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic [31:0] data,
                      input logic ovf);
        m_data = data;
        m_zero = (data == 32'h0);
        m_topc = (op == 4'b1011);
        m_ovf  = ovf;
        push(tag, cyc + 1, 1'b0);
        drive(op, a, b, sh);
    endtask

    task automatic md(input logic [63:0] tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                      input logic dbz, input int lat);
        m_hi = hi;
        m_lo = lo;
        push(tag, cyc + lat, dbz);
        drive(op, a, b, 5'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || bus.busy_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_budget", 32'(n < 200), 32'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done_o), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("%s.cycle", mon_e.tag), cyc, mon_e.due);
                chk($sformatf("%s.busy", mon_e.tag), 32'(bus.busy_o), 32'd0);
                chk($sformatf("%s.data", mon_e.tag), bus.alu_data_o, mon_e.data);
                chk($sformatf("%s.zero", mon_e.tag), 32'(bus.zero_o), 32'(mon_e.zero));
                chk($sformatf("%s.topc", mon_e.tag), 32'(bus.topc_o), 32'(mon_e.topc));
                chk($sformatf("%s.hi", mon_e.tag), bus.hi_o, mon_e.hi);
                chk($sformatf("%s.lo", mon_e.tag), bus.lo_o, mon_e.lo);
                chk($sformatf("%s.dbz", mon_e.tag), 32'(bus.div_by_zero_o), 32'(mon_e.dbz));
`ifdef ALU_OVF_EN
                chk($sformatf("%s.ovf", mon_e.tag), 32'(bus.overflow_o), 32'(mon_e.ovf));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start_i         = 1'b0;
        bus.alu_operation_i = 4'h0;
        bus.a_i             = '0;
        bus.b_i             = '0;
        bus.shamt_i         = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        chk("rst.done", 32'(bus.done_o), 32'd0);
        chk("rst.data", bus.alu_data_o, 32'd0);
        chk("rst.zero", 32'(bus.zero_o), 32'd0);
        chk("rst.topc", 32'(bus.topc_o), 32'd0);
        chk("rst.hi", bus.hi_o, 32'd0);
        chk("rst.lo", bus.lo_o, 32'd0);
        chk("rst.dbz", 32'(bus.div_by_zero_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single-cycle ops, issued back to back
        sc("ADD", 4'b0011, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0);
        sc("SUB", 4'b0001, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0);
        sc("OR", 4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0);
        sc("AND", 4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00, 1'b0);
        sc("NOR0", 4'b1000, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        sc("NOR1", 4'b1000, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 32'h0, 1'b0);
        sc("LUI", 4'b0100, 32'h1234_5678, 32'h9999_ABCD, 5'd0, 32'hABCD_0000, 1'b0);
        sc("SLL", 4'b0101, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b0);
        sc("SRL", 4'b0110, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
        sc("SLTT", 4'b1001, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0);
        sc("SLTF", 4'b1001, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0);
        sc("TOPC", 4'b1011, 32'h0040_0020, 32'h0, 5'd0, 32'h0040_0020, 1'b0);
        sc("OP0", 4'b0000, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b0);
        sc("ADDWRAP", 4'b0011, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
        sc("ADDOVF", 4'b0011, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1);
        sc("SUBOVF", 4'b0001, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1);
        wait_done();

        // MULT with an ADD issued mid-flight that must be ignored
        md("MULT", 4'b1100, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, W + 1);
        n = 0;
        while (bus.busy_o && n < 100) begin
            if (n == 10) begin
                bus.start_i         = 1'b1;
                bus.alu_operation_i = 4'b0011;
                bus.a_i             = 32'd1;
                bus.b_i             = 32'd1;
            end else begin
                bus.start_i = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        chk("MULT.busy_cycles", n, W);
        wait_done();

        md("MULTU", 4'b1101, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, W + 1);
        wait_done();
        md("DIV", 4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1);
        wait_done();
        md("DIVU", 4'b1111, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1);
        wait_done();
        md("DIVMIN", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, W + 1);
        wait_done();
        md("DIV0", 4'b1111, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1);
        wait_done();

        // single-cycle op after MDU work leaves HI/LO alone
        sc("ADDHOLD", 4'b0011, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
        wait_done();

        // reset in the middle of a divide aborts it immediately
        drive(4'b1111, 32'd100, 32'd7, 5'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort.busy", 32'(bus.busy_o), 32'd0);
        chk("abort.done", 32'(bus.done_o), 32'd0);
        chk("abort.hi", bus.hi_o, 32'd0);
        chk("abort.lo", bus.lo_o, 32'd0);
        chk("abort.data", bus.alu_data_o, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        m_data = '0; m_zero = 1'b0; m_topc = 1'b0; m_ovf = 1'b0; m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);

        sc("ADDRST", 4'b0011, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0);
        wait_done();
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
